random_range_gen: RTL and testbench
===================================

# random_range_gen

Parametrised successor to the team's 5-bit free-running random source. It is a configurable-width Galois LFSR with runtime seed loading and zero-seed lock-up protection. On a request handshake it returns one value uniformly in 0..RANGE-1, using bounded rejection sampling. Game logic uses it for spawn positions, item selection and similar bounded draws.

## Interface
- LFSR_W, 16: LFSR state width.
- OUT_W, 5: output width. Constraint: 2^(OUT_W-1) < RANGE <= 2^OUT_W.
- RANGE, 20: exclusive upper bound of returned values.
- TAPS, 16'hB400: Galois feedback mask. The default gives the maximal period 65535.
- SEED, 16'hACE1: reset seed. Also the substitute whenever a zero seed is loaded.
- MAX_TRY, 3: rejections allowed before the fallback value is used.
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- seed_load, input, 1: load seed into the LFSR on this edge.
- seed, input, LFSR_W: seed value.
- req, input, 1: request one draw. Sampled only in IDLE.
- data, output, OUT_W: drawn value. Registered; held until the next draw completes.
- valid, output, 1: one-cycle pulse marking new data.
- busy, output, 1: high while state is DRAW.

## Operation
- Reset (rst low, asynchronous): lfsr = SEED, state = IDLE, tries = 0, data = 0, valid = 0, busy = 0.
- LFSR advances on every edge, whether or not a draw is in progress, so user timing adds entropy.
- Advance rule: if lfsr[0] is 1, lfsr <= (lfsr >> 1) ^ TAPS; otherwise lfsr <= lfsr >> 1.
- seed_load has priority over advance: lfsr <= (seed == 0) ? SEED : seed. The LFSR never holds zero.
- State IDLE:
  - req=1 and seed_load=0 → DRAW, tries <= 0.
  - req together with seed_load is ignored.
- State DRAW, evaluated each edge:
  - cand = low OUT_W bits of lfsr, taken before this edge's update.
  - seed_load=1 aborts the draw: → IDLE, no valid, data unchanged.
  - cand < RANGE: data <= cand, valid <= 1, → IDLE.
  - cand >= RANGE and tries == MAX_TRY: data <= cand - RANGE, valid <= 1, → IDLE. The RANGE constraint guarantees this result is < RANGE.
  - Otherwise: tries <= tries + 1 and stay in DRAW.
- req while busy is ignored; requests are not queued.
- valid is cleared on the edge after it is set.
- busy is decoded combinationally from the state register.
- Arithmetic: tries is a counter of width clog2(MAX_TRY+1). cand - RANGE uses OUT_W+1 bits internally and is truncated to OUT_W.

## Timing
- Latency: req sampled at edge e1; valid goes high after edge e1+1+k, where k is the number of rejections, 0..MAX_TRY.
- Maximum latency is MAX_TRY+1 edges after the request edge.
- Back-to-back: the IDLE return and a new req overlap, so a new req can be accepted on the edge right after valid rises. Peak throughput is one draw per 2 cycles.
- Reset asserted mid-draw clears valid and busy immediately, with no clock edge needed.
- Reset release takes effect on the first following edge. Reset release must be synchronous to clk, which is a top-level responsibility.
- No combinational path from any input to any output.

## Test plan
All scenarios use default parameters unless stated otherwise.
- Reset: hold rst low with no clocks → data=0, valid=0, busy=0. Release rst, keep req=0 for 10 cycles → valid stays 0.
- Accept on first try: e0 seed_load, seed=16'h0001; e1 req=1 (lfsr becomes B400); e2 cand=0 → valid high for exactly one cycle, data=0, busy high only between e1 and e2.
- Rejection then accept: e0 seed=16'h003E; e1 req (lfsr=001F); e2 cand=31 rejected, busy stays high, valid=0; e3 cand=15 → data=15, valid pulse.
- Fallback: MAX_TRY=0, same stimulus as the rejection case → at e2 data=11 (31-20), valid pulse.
- Zero seed: seed_load with seed=0, then req → lfsr=E270 at the draw edge; data=16. Over 70000 cycles lfsr is never 0 and the period is 65535.
- Abort and reset: start the seed=003E draw, assert seed_load at e2 → no valid, data unchanged, busy low. Repeat with rst pulsed low mid-draw → valid=0 and busy=0 asynchronously. A req 1000 times → every data < 20 and no data >= RANGE.

Source files
------------

// File: rtl/random_range_gen.sv
// rtl/random_range_gen.sv - Galois LFSR with bounded rejection sampling into 0..RANGE-1
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_seed_load  load i_seed into the LFSR on this edge (zero seed maps to SEED)
//   i_seed       seed value, LFSR_W bits
//   i_req        request one draw, sampled only while idle
//   o_data       drawn value, held until the next draw completes
//   o_valid      one-cycle pulse marking new o_data
//   o_busy       high while a draw is in progress

module random_range_gen #(
    parameter int                LFSR_W  = 16,
    parameter int                OUT_W   = 5,
    parameter int                RANGE   = 20,
    parameter logic [LFSR_W-1:0] TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED    = 16'hACE1,
    parameter int                MAX_TRY = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_seed_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_req,
    output logic [OUT_W-1:0]  o_data,
    output logic              o_valid,
    output logic              o_busy
);

    // A zero-width counter is not legal, so MAX_TRY = 0 still gets one bit.
    localparam int TRY_W = (MAX_TRY > 0) ? $clog2(MAX_TRY + 1) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  w_lfsr_adv;
    logic [LFSR_W-1:0]  w_lfsr_next;
    logic [TRY_W-1:0]   r_tries;
    logic [TRY_W-1:0]   w_tries_next;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   w_data_next;
    logic               r_valid;
    logic               w_valid_next;
    logic [OUT_W-1:0]   w_cand;
    logic [OUT_W-1:0]   w_fallback;
    logic               w_accept;
    logic               w_last_try;

    // Free-running advance; a seed load overrides it and never leaves zero in the register.
    assign w_lfsr_adv  = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign w_lfsr_next = i_seed_load ? ((i_seed == '0) ? SEED : i_seed) : w_lfsr_adv;

    // Candidate is taken from the pre-update LFSR value.
    assign w_cand     = r_lfsr[OUT_W-1:0];
    assign w_accept   = {1'b0, w_cand} < (OUT_W + 1)'(RANGE);
    assign w_last_try = (r_tries == TRY_W'(MAX_TRY));
    // With RANGE > 2^(OUT_W-1) a rejected candidate minus RANGE always lands
    // inside the range, and the subtraction wraps cleanly modulo 2^OUT_W.
    assign w_fallback = w_cand - OUT_W'(RANGE);

    always_comb begin
        w_state_next = r_state;
        w_tries_next = r_tries;
        w_data_next  = r_data;
        w_valid_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req && !i_seed_load) begin
                    w_state_next = S_DRAW;
                    w_tries_next = '0;
                end
            end
            S_DRAW: begin
                if (i_seed_load) begin
                    w_state_next = S_IDLE;
                end else if (w_accept) begin
                    w_data_next  = w_cand;
                    w_valid_next = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_last_try) begin
                    w_data_next  = w_fallback;
                    w_valid_next = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_tries_next = r_tries + TRY_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr  <= SEED;
            r_state <= S_IDLE;
            r_tries <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_lfsr  <= w_lfsr_next;
            r_state <= w_state_next;
            r_tries <= w_tries_next;
            r_data  <= w_data_next;
            r_valid <= w_valid_next;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_busy  = (r_state == S_DRAW);

endmodule

// File: tb/tb_random_range_gen.sv
// tb/tb_random_range_gen.sv - self-checking bench for random_range_gen

module tb_random_range_gen;

    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          RANGE = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seed_load;
    logic [15:0] seed;
    logic        req;
    logic [4:0]  data,  data_fb;
    logic        valid, valid_fb;
    logic        busy,  busy_fb;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    random_range_gen dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_seed_load (seed_load),
        .i_seed      (seed),
        .i_req       (req),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy)
    );

    random_range_gen #(.MAX_TRY(0)) dut_fb (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_seed_load (seed_load),
        .i_seed      (seed),
        .i_req       (req),
        .o_data      (data_fb),
        .o_valid     (valid_fb),
        .o_busy      (busy_fb)
    );

    function automatic logic [15:0] adv(input logic [15:0] x);
        if (x % 2 == 1) return (x / 2) ^ TAPS;
        return x / 2;
    endfunction

    // Predict result and rejection count for a request taken when the LFSR holds l.
    task automatic predict(input logic [15:0] l, input int max_try, output int d, output int k);
        logic [15:0] s;
        int c;
        bit done;
        s = adv(l);
        done = 0;
        d = 0;
        k = 0;
        for (int i = 0; i <= max_try; i++) begin
            if (!done) begin
                c = s % 32;
                if (c < RANGE) begin
                    d = c; k = i; done = 1;
                end else if (i == max_try) begin
                    d = c - RANGE; k = i; done = 1;
                end
                s = adv(s);
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] nx;
        if (!rst_n)         nx = SEED;
        else if (seed_load) nx = (seed == 16'h0) ? SEED : seed;
        else                nx = adv(m_lfsr);
        @(posedge clk);
        m_lfsr = nx;
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, k, lat, gap, zero_seen, period;
        bit found;

        rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0; req = 1'b0;
        m_lfsr = SEED;

        // Reset state before any clock edge
        #1;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", valid, 0);
        end
        chk("idle_busy", busy, 0);
        chk("lfsr_free_run", dut.r_lfsr, m_lfsr);

        // Accept on first try
        seed_load = 1'b1; seed = 16'h0001; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0;
        chk("acc_lfsr", dut.r_lfsr, 16'hB400);
        chk("acc_busy_e1", busy, 1);
        chk("acc_valid_e1", valid, 0);
        tick();
        chk("acc_valid_e2", valid, 1);
        chk("acc_data_e2", data, 0);
        chk("acc_busy_e2", busy, 0);
        tick();
        chk("acc_valid_pulse", valid, 0);
        chk("acc_data_hold", data, 0);

        // Rejection then accept; fallback instance returns 31-20 at once
        seed_load = 1'b1; seed = 16'h003E; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0;
        chk("rej_lfsr", dut.r_lfsr, 16'h001F);
        tick();
        chk("rej_valid_e2", valid, 0);
        chk("rej_busy_e2", busy, 1);
        chk("fb_valid_e2", valid_fb, 1);
        chk("fb_data_e2", data_fb, 11);
        tick();
        chk("rej_valid_e3", valid, 1);
        chk("rej_data_e3", data, 15);
        tick();

        // Zero seed substitutes SEED
        seed_load = 1'b1; seed = 16'h0000; tick();
        seed_load = 1'b0;
        chk("zero_lfsr", dut.r_lfsr, SEED);
        req = 1'b1; tick();
        req = 1'b0;
        chk("zero_lfsr_draw", dut.r_lfsr, 16'hE270);
        tick();
        chk("zero_valid", valid, 1);
        chk("zero_data", data, 16);
        tick();

        // Seed load aborts a draw in progress
        seed_load = 1'b1; seed = 16'h003E; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0;
        seed_load = 1'b1; seed = 16'h1234; tick();
        seed_load = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", data, 16);
        chk("abort_lfsr", dut.r_lfsr, 16'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_valid", valid, 0);
        end

        // Asynchronous reset mid-draw clears busy
        seed_load = 1'b1; seed = 16'h003E; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0;
        chk("rstmid_busy_before", busy, 1);
        rst_n = 1'b0; m_lfsr = SEED;
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_valid", valid, 0);
        tick();
        rst_n = 1'b1;

        // Asynchronous reset while valid is high clears it
        seed_load = 1'b1; seed = 16'h0001; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0; tick();
        chk("rstv_valid_before", valid, 1);
        rst_n = 1'b0; m_lfsr = SEED;
        #1;
        chk("rstv_valid", valid, 0);
        chk("rstv_data", data, 0);
        tick();
        rst_n = 1'b1;
        chk("rstv_lfsr", dut.r_lfsr, SEED);

        // Full period: never zero, first return to the seed after 65535 steps
        seed_load = 1'b1; seed = 16'h0001; tick();
        seed_load = 1'b0;
        zero_seen = 0; period = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (dut.r_lfsr == 16'h0) zero_seen++;
            if (period == 0 && dut.r_lfsr == 16'h0001) period = i;
        end
        chk("period_no_zero", zero_seen, 0);
        chk("period_len", period, 65535);
        chk("period_model", dut.r_lfsr, m_lfsr);

        // Randomized draws against the reference model
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            if ($urandom_range(0, 7) == 0) begin
                seed_load = 1'b1;
                seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                tick();
                seed_load = 1'b0;
            end
            predict(m_lfsr, 3, d, k);
            req = 1'b1; tick();
            req = 1'b0;
            found = 0; lat = -1;
            for (int t = 0; t <= 4; t++) begin
                if (!found) begin
                    tick();
                    if (valid) begin
                        found = 1; lat = t;
                    end
                end
            end
            chk("rnd_valid_seen", found, 1);
            chk("rnd_data", data, d);
            chk("rnd_latency", lat, k);
            chk("rnd_in_range", (data < RANGE), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
